// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU control path: sequencer states, special
// opcodes, condition codes and ALU flag bit positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StWriteback,
    StHalt,
    StFault
  } state_e;

  localparam logic [3:0] OPC_BRANCH = 4'hE;
  localparam logic [3:0] OPC_HALT   = 4'hF;

  localparam logic [3:0] COND_AL = 4'd0;
  localparam logic [3:0] COND_EQ = 4'd1;
  localparam logic [3:0] COND_NE = 4'd2;
  localparam logic [3:0] COND_CS = 4'd3;
  localparam logic [3:0] COND_CC = 4'd4;
  localparam logic [3:0] COND_MI = 4'd5;
  localparam logic [3:0] COND_PL = 4'd6;
  localparam logic [3:0] COND_VS = 4'd7;
  localparam logic [3:0] COND_VC = 4'd8;
  localparam logic [3:0] COND_HI = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  // Codes 12..15 all mean "never".
  localparam logic [3:0] COND_NV = 4'd12;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code check: decides whether an instruction with the
// given condition field executes under the current ALU flags.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_AL: pass = 1'b1;
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: owns the PC, sequences ROM / register bank / ALU and
// resolves conditional execution, branches, halts and ALU timeouts.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W        = 3,
  parameter int unsigned ALU_TIMEOUT = 15,
  parameter int unsigned RET_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic [3:0]       cond,
  input  logic [PC_W-1:0]  branch_target,
  input  logic [3:0]       flags,
  input  logic             alu_done,
  output logic [PC_W-1:0]  pc,
  output logic             rom_oe_n,
  output logic             ram_ce,
  output logic             ram_rw,
  output logic             alu_execute,
  output logic             halted,
  output logic             fault,
  output logic [RET_W-1:0] retired
);

  localparam int unsigned TmoW = $clog2(ALU_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [RET_W-1:0]  retired_q, retired_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [TmoW:0]     tmo_inc;
  logic              retire;
  logic              cond_pass;

  cond_eval u_cond_eval (
    .cond  (cond),
    .flags (flags),
    .pass  (cond_pass)
  );

  // One extra bit so the limit compare cannot alias on wrap.
  assign tmo_inc = {1'b0, tmo_q} + (TmoW + 1)'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tmo_d   = tmo_q;
    retire  = 1'b0;
    case (state_q)
      StIdle:  if (run) state_d = StFetch;
      StFetch: state_d = StDecode;
      StDecode: begin
        if (!cond_pass) begin
          pc_d    = pc_q + PC_W'(1);
          retire  = 1'b1;
          state_d = StFetch;
        end else if (opcode == OPC_HALT) begin
          retire  = 1'b1;
          state_d = StHalt;
        end else if (opcode == OPC_BRANCH) begin
          pc_d    = branch_target;
          retire  = 1'b1;
          state_d = StFetch;
        end else begin
          tmo_d   = '0;
          state_d = StExecute;
        end
      end
      StExecute: begin
        // A completion in the same cycle as the limit still wins.
        if (alu_done) begin
          state_d = StWriteback;
        end else if (tmo_inc == (TmoW + 1)'(ALU_TIMEOUT)) begin
          state_d = StFault;
        end else begin
          tmo_d = tmo_inc[TmoW-1:0];
        end
      end
      StWriteback: begin
        pc_d    = pc_q + PC_W'(1);
        retire  = 1'b1;
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase

    retired_d = retired_q;
    if (retire && (retired_q != '1)) retired_d = retired_q + RET_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      retired_q <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    rom_oe_n    = 1'b1;
    ram_ce      = 1'b0;
    ram_rw      = 1'b1;
    alu_execute = 1'b0;
    case (state_q)
      StFetch:     rom_oe_n = 1'b0;
      StDecode:    ram_ce = 1'b1;
      StExecute: begin
        ram_ce      = 1'b1;
        alu_execute = 1'b1;
      end
      StWriteback: begin
        ram_ce = 1'b1;
        ram_rw = 1'b0;
      end
      default: ;
    endcase
  end

  assign pc      = pc_q;
  assign retired = retired_q;
  assign halted  = (state_q == StHalt);
  assign fault   = (state_q == StFault);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed and random instructions are
// predicted per instruction from the condition/opcode rules and compared cycle by cycle.
module tb_cpu_sequencer;

  localparam int unsigned PCW = 3;
  localparam int unsigned TMO = 15;
  localparam int unsigned RW  = 16;

  // {rom_oe_n, ram_ce, ram_rw, alu_execute}
  localparam logic [3:0] O_IDLE  = 4'b1010;
  localparam logic [3:0] O_FETCH = 4'b0010;
  localparam logic [3:0] O_DEC   = 4'b1110;
  localparam logic [3:0] O_EXEC  = 4'b1111;
  localparam logic [3:0] O_WB    = 4'b1100;

  logic           clock = 1'b0;
  logic           reset_n, run, alu_done;
  logic [3:0]     opcode, cond, flags;
  logic [PCW-1:0] branch_target;
  logic [PCW-1:0] pc;
  logic           rom_oe_n, ram_ce, ram_rw, alu_execute, halted, fault;
  logic [RW-1:0]  retired;

  int tests = 0;
  int fails = 0;

  int unsigned m_pc, m_ret;
  logic        m_halted, m_fault;

  cpu_sequencer #(
    .PC_W        (PCW),
    .ALU_TIMEOUT (TMO),
    .RET_W       (RW)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .run           (run),
    .opcode        (opcode),
    .cond          (cond),
    .branch_target (branch_target),
    .flags         (flags),
    .alu_done      (alu_done),
    .pc            (pc),
    .rom_oe_n      (rom_oe_n),
    .ram_ce        (ram_ce),
    .ram_rw        (ram_rw),
    .alu_execute   (alu_execute),
    .halted        (halted),
    .fault         (fault),
    .retired       (retired)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] exp_outs);
    check({tag, ".outs"}, 32'({rom_oe_n, ram_ce, ram_rw, alu_execute}), 32'(exp_outs));
    check({tag, ".pc"}, 32'(pc), m_pc);
    check({tag, ".retired"}, 32'(retired), m_ret);
    check({tag, ".halted"}, 32'(halted), 32'(m_halted));
    check({tag, ".fault"}, 32'(fault), 32'(m_fault));
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (int'(c))
      0:  return 1;
      1:  return z;
      2:  return !z;
      3:  return cy;
      4:  return !cy;
      5:  return n;
      6:  return !n;
      7:  return v;
      8:  return !v;
      9:  return cy && !z;
      10: return n == v;
      11: return n != v;
      default: return 0;
    endcase
  endfunction

  function automatic void reset_model();
    m_pc = 0; m_ret = 0; m_halted = 0; m_fault = 0;
  endfunction

  // Entered at a falling edge with the DUT expected in FETCH; returns at the falling
  // edge after the instruction's last cycle. stall = EXECUTE cycles with alu_done low.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [3:0] c,
                           input logic [3:0] f, input logic [PCW-1:0] tgt, input int stall);
    logic [3:0] seq[$];
    bit         pass;
    bit         alu_op;
    pass   = cond_ok(c, f);
    alu_op = pass && (op != 4'hE) && (op != 4'hF);
    opcode = op; cond = c; flags = f; branch_target = tgt; alu_done = 1'b0;
    seq.push_back(O_FETCH);
    seq.push_back(O_DEC);
    if (alu_op) begin
      for (int k = 0; k <= stall && k < int'(TMO); k++) seq.push_back(O_EXEC);
      if (stall < int'(TMO)) seq.push_back(O_WB);
    end
    for (int i = 0; i < seq.size(); i++) begin
      check_all(tag, seq[i]);
      alu_done = (i >= 2) && (i - 2 >= stall);
      @(negedge clock);
    end
    alu_done = 1'b0;
    if (!pass) begin
      m_pc = (m_pc + 1) % (1 << PCW); m_ret++;
    end else if (op == 4'hF) begin
      m_halted = 1; m_ret++;
    end else if (op == 4'hE) begin
      m_pc = int'(tgt); m_ret++;
    end else if (stall < int'(TMO)) begin
      m_pc = (m_pc + 1) % (1 << PCW); m_ret++;
    end else begin
      m_fault = 1;
    end
  endtask

  task automatic reset_and_start();
    reset_n = 1'b0; run = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    reset_model();
    check_all("post_reset", O_IDLE);
    run = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; opcode = '0; cond = '0; flags = '0;
    branch_target = '0; alu_done = 1'b0;
    reset_model();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_all("idle_run0", O_IDLE);
      @(negedge clock);
    end
    run = 1'b1;
    @(negedge clock);

    run_instr("alu_basic", 4'h1, 4'd0, 4'b0000, 3'd0, 0);
    run = 1'b0;
    run_instr("skip_eq", 4'h2, 4'd1, 4'b0000, 3'd0, 0);
    run_instr("exec_eq", 4'h2, 4'd1, 4'b0100, 3'd0, 0);
    run_instr("branch5", 4'hE, 4'd0, 4'b0000, 3'd5, 0);
    run_instr("branch7", 4'hE, 4'd0, 4'b0000, 3'd7, 0);
    run_instr("wrap", 4'h3, 4'd0, 4'b0000, 3'd0, 0);
    run_instr("stall3", 4'h4, 4'd0, 4'b0000, 3'd0, 3);
    run_instr("done_at_limit", 4'h5, 4'd0, 4'b0000, 3'd0, int'(TMO) - 1);
    run_instr("halt_never", 4'hF, 4'd12, 4'b1111, 3'd0, 0);
    run_instr("branch_never", 4'hE, 4'd15, 4'b0000, 3'd2, 0);

    for (int n = 0; n < 60; n++) begin
      run_instr("random", 4'($urandom_range(0, 14)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), PCW'($urandom_range(0, 7)),
                int'($urandom_range(0, 4)));
    end

    // Reset while the ALU is still busy.
    opcode = 4'h6; cond = 4'd0; alu_done = 1'b0;
    check_all("mid.fetch", O_FETCH);
    @(negedge clock);
    check_all("mid.decode", O_DEC);
    @(negedge clock);
    check_all("mid.exec", O_EXEC);
    reset_n = 1'b0;
    @(negedge clock);
    reset_model();
    check_all("mid.reset", O_IDLE);
    reset_n = 1'b1;
    run = 1'b1;
    @(negedge clock);

    run_instr("pre_halt", 4'h7, 4'd0, 4'b0000, 3'd0, 1);
    run_instr("halt", 4'hF, 4'd0, 4'b0000, 3'd0, 0);
    for (int i = 0; i < 3; i++) begin
      check_all("halted_hold", O_IDLE);
      @(negedge clock);
    end

    reset_and_start();
    run_instr("timeout", 4'h8, 4'd0, 4'b0000, 3'd0, int'(TMO));
    for (int i = 0; i < 3; i++) begin
      check_all("fault_hold", O_IDLE);
      @(negedge clock);
    end

    reset_and_start();
    run_instr("after_fault", 4'h9, 4'd10, 4'b1001, 3'd0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
